a09_input_port: RTL and testbench
=================================

Name: a09_input_port

Overview:
- Input-direction counterpart of the A09 output register path. Brings external FPGA pins into the CPU clock domain.
- Synchronizes an 8-bit pin bus and a pushbutton strobe, then debounces the strobe. On each debounced press it captures the pin byte into a small FIFO.
- The CPU drains the FIFO with a ready/read handshake. Sits in the FPGA top level, between the pins and the CPU input-load path.

Parameters:
- DataWidth, 16, width of In_Data presented to the CPU; captured byte is zero-extended.
- PinWidth, 8, number of external data pins; must be ≤ DataWidth.
- DebounceCycles, 16, consecutive stable cycles required before the debounced strobe changes; ≥1.
- Depth, 2, FIFO entries; power of 2, ≥2.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- Pins_In  input  PinWidth  raw asynchronous data pins.
- Strobe_In  input  1  raw asynchronous pushbutton; active-high press.
- In_Rd  input  1  CPU pops the head entry this cycle.
- Clr_Ovf  input  1  clears the Overflow flag.
- In_Data  output  DataWidth  head entry, zero-extended; valid only while In_Rdy=1.
- In_Rdy  output  1  FIFO non-empty.
- In_Full  output  1  FIFO holds Depth entries.
- Overflow  output  1  sticky flag: a capture was dropped.

Behaviour:
- Reset (asynchronous, active-high):
  - Both synchronizer stages and the debounced level go to 0. Debounce counter goes to 0.
  - FIFO read/write pointers and occupancy go to 0.
  - Outputs: In_Rdy=0, In_Full=0, Overflow=0, In_Data=0.
  - Reset mid-operation discards all buffered entries and any in-progress debounce count.
- Synchronizers: 2-flop synchronizer on each Pins_In bit and on Strobe_In. Gives sync_pins and sync_strobe.
- Debounce:
  - When sync_strobe equals the debounced level, the counter clears to 0.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DebounceCycles-1 and sync_strobe still differs, the debounced level toggles on that edge and the counter clears.
  - A glitch shorter than DebounceCycles cycles never toggles the level.
- Capture:
  - On the cycle the debounced level is 1 and its registered copy is 0 (a rising edge), push {zeros, sync_pins} sampled that same cycle.
  - A falling edge does nothing. Exactly one push per press.
- Latency: with Strobe_In rising before edge 0 and held stable, In_Rdy is 1 after edge DebounceCycles+3.
- FIFO:
  - Circular buffer with pointers of width log2(Depth), plus an occupancy counter of width log2(Depth)+1.
  - Pointers wrap from Depth-1 to 0.
  - In_Data is driven from the head entry register, not a combinational mux of the pins.
- Boundary cases:
  - Pop when empty (In_Rd=1, In_Rdy=0): ignored; no pointer or count change.
  - Push when full with no pop: the data is dropped and Overflow is set.
  - Push and pop in the same cycle while full: both proceed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push proceeds and the pop is ignored; In_Rdy=1 next cycle.
- Overflow is cleared by Clr_Ovf. If Clr_Ovf and a dropped push occur in the same cycle, the set wins (Overflow=1).

Decomposition:
- Shared include (a09 constants file): DebounceCycles default, and the localparams for PinWidth/DataWidth used by the top level.
- Counter and pointer widths are derived with $clog2 inside the module. No typedefs.
- One sub-module: a09_sync_debounce, containing the 2-flop synchronizer, the debounce counter, and a registered rise-pulse output.
- The 8-bit data synchronizer and the FIFO stay in a09_input_port.

Test Plan (DebounceCycles=4, Depth=2):
- Pins_In=8'hA5; Strobe_In high for 20 cycles from edge 0 → In_Rdy=1 after edge 7, In_Data=16'h00A5, exactly one entry.
- Strobe_In pulse high for 3 cycles (shorter than DebounceCycles) → In_Rdy stays 0, no capture.
- Three presses with pins 8'h11, 8'h22, 8'h33 and no In_Rd → In_Full=1, Overflow=1; then pops return 16'h0011 and 16'h0022, and In_Rdy=0 after the second pop.
- FIFO full, with the third press's capture cycle coinciding with In_Rd=1 → pop returns 16'h0011, the new entry is accepted, Overflow stays 0, count stays 2.
- Overflow=1; assert Clr_Ovf alone → Overflow=0 next cycle. Repeat with Clr_Ovf coinciding with a dropped push → Overflow stays 1.
- Assert Reset asynchronously while one entry is buffered and debounce is mid-count → outputs 0 immediately; after release, a new press yields latency 7 again.

Source files
------------

// File: rtl/a09_input_port_pkg.sv
// Shared A09 input-path constants: default widths, debounce length and FIFO depth,
// plus a width helper used for small counters.
package a09_input_port_pkg;

    localparam int A09_DEBOUNCE_CYCLES = 16;
    localparam int A09_PIN_WIDTH       = 8;
    localparam int A09_DATA_WIDTH      = 16;
    localparam int A09_FIFO_DEPTH      = 2;

    // A counter that must hold 0..n-1; never narrower than one bit.
    function automatic int a09_cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/a09_input_port_sync_debounce.sv
// Two-flop synchronizer and debouncer for the pushbutton strobe; emits a
// one-cycle registered pulse on each debounced press.
module a09_sync_debounce
    import a09_input_port_pkg::*;
#(
    parameter int DebounceCycles = A09_DEBOUNCE_CYCLES
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Strobe_In,
    output logic Rise
);

    localparam int CNT_W = a09_cnt_width(DebounceCycles);

    logic             sync1;
    logic             sync_strobe;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1       <= 1'b0;
            sync_strobe <= 1'b0;
            level       <= 1'b0;
            level_d     <= 1'b0;
            cnt         <= '0;
            Rise        <= 1'b0;
        end else begin
            sync1       <= Strobe_In;
            sync_strobe <= sync1;

            // Any sample agreeing with the current level restarts the stability run.
            if (sync_strobe == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DebounceCycles - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            level_d <= level;
            Rise    <= level & ~level_d;
        end
    end

endmodule

// File: rtl/a09_input_port.sv
// A09 input port: synchronizes the pin bus, captures it on each debounced
// strobe press into a small FIFO, and hands entries to the CPU by ready/read.
module a09_input_port
    import a09_input_port_pkg::*;
#(
    parameter int DataWidth      = A09_DATA_WIDTH,
    parameter int PinWidth       = A09_PIN_WIDTH,
    parameter int DebounceCycles = A09_DEBOUNCE_CYCLES,
    parameter int Depth          = A09_FIFO_DEPTH
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [PinWidth-1:0]  Pins_In,
    input  logic                 Strobe_In,
    input  logic                 In_Rd,
    input  logic                 Clr_Ovf,
    output logic [DataWidth-1:0] In_Data,
    output logic                 In_Rdy,
    output logic                 In_Full,
    output logic                 Overflow
);

    localparam int PTR_W = $clog2(Depth);
    localparam int CNT_W = PTR_W + 1;

    logic [PinWidth-1:0]  pins_s1;
    logic [PinWidth-1:0]  sync_pins;
    logic [DataWidth-1:0] mem [Depth];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;

    logic capture;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    a09_sync_debounce #(
        .DebounceCycles(DebounceCycles)
    ) u_strobe (
        .Clk       (Clk),
        .Reset     (Reset),
        .Strobe_In (Strobe_In),
        .Rise      (capture)
    );

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(Depth));

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign pop  = In_Rd & ~empty;
    assign push = capture & (~full | pop);
    assign drop = capture & full & ~pop;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pins_s1   <= '0;
            sync_pins <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            Overflow  <= 1'b0;
            for (int i = 0; i < Depth; i++) mem[i] <= '0;
        end else begin
            pins_s1   <= Pins_In;
            sync_pins <= pins_s1;

            if (push) begin
                mem[wr_ptr] <= DataWidth'(sync_pins);
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;

            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            // A dropped capture beats a simultaneous clear.
            if (drop)         Overflow <= 1'b1;
            else if (Clr_Ovf) Overflow <= 1'b0;
        end
    end

    assign In_Rdy  = ~empty;
    assign In_Full = full;
    assign In_Data = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_a09_input_port.sv
// Bench for a09_input_port (DebounceCycles=4, Depth=2): directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_a09_input_port;

    localparam int DC    = 4;
    localparam int DEPTH = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [7:0]  Pins_In;
    logic        Strobe_In;
    logic        In_Rd;
    logic        Clr_Ovf;
    logic [15:0] In_Data;
    logic        In_Rdy;
    logic        In_Full;
    logic        Overflow;

    int n_vec = 0;
    int n_err = 0;

    a09_input_port #(
        .DataWidth(16), .PinWidth(8), .DebounceCycles(DC), .Depth(DEPTH)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Pins_In(Pins_In), .Strobe_In(Strobe_In),
        .In_Rd(In_Rd), .Clr_Ovf(Clr_Ovf), .In_Data(In_Data), .In_Rdy(In_Rdy),
        .In_Full(In_Full), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    // Reference model: pins/strobe seen two edges late; level flips after DC
    // consecutive disagreeing samples; a press is stored two edges after the flip.
    logic [15:0] mq[$];
    bit          win[$];
    bit          m_ovf, m_level, m_s1, m_s2, m_r1, m_r2;
    bit          m_pop, m_push, m_full, m_all;
    logic [7:0]  m_p1, m_p2;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            mq.delete(); win.delete();
            m_ovf = 0; m_level = 0; m_s1 = 0; m_s2 = 0; m_r1 = 0; m_r2 = 0;
            m_p1 = '0; m_p2 = '0;
        end else begin
            m_push = m_r2;
            m_full = (mq.size() == DEPTH);
            m_pop  = In_Rd && (mq.size() != 0);
            if (m_pop) void'(mq.pop_front());
            if (m_push && m_full && !m_pop) m_ovf = 1;
            else if (Clr_Ovf)               m_ovf = 0;
            if (m_push && (!m_full || m_pop)) mq.push_back({8'h00, m_p2});

            win.push_back(m_s2);
            if (win.size() > DC) void'(win.pop_front());
            m_all = (win.size() == DC);
            foreach (win[i]) if (win[i] == m_level) m_all = 0;
            m_r2 = m_r1;
            m_r1 = 0;
            if (m_all) begin
                m_level = ~m_level;
                m_r1    = m_level;
                win.delete();
            end

            m_s2 = m_s1; m_s1 = Strobe_In;
            m_p2 = m_p1; m_p1 = Pins_In;
        end
    end

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Press the button with a given pin byte; optional read/clear on the capture edge.
    task automatic press(input logic [7:0] b, input bit rd_cap, input bit clr_cap);
        Pins_In   = b;
        Strobe_In = 1'b1;
        for (int e = 0; e < 8; e++) begin
            In_Rd   = (e == 7) ? rd_cap : 1'b0;
            Clr_Ovf = (e == 7) ? clr_cap : 1'b0;
            step();
        end
        In_Rd = 0; Clr_Ovf = 0; Strobe_In = 0;
        repeat (8) step();
    endtask

    task automatic test_reset();
        Reset = 1; Pins_In = 0; Strobe_In = 0; In_Rd = 0; Clr_Ovf = 0;
        @(negedge Clk);
        n_vec++; if (In_Rdy !== 1'b0)     begin n_err++; $display("FAIL reset_rdy got %b exp 0", In_Rdy); end
        n_vec++; if (In_Full !== 1'b0)    begin n_err++; $display("FAIL reset_full got %b exp 0", In_Full); end
        n_vec++; if (Overflow !== 1'b0)   begin n_err++; $display("FAIL reset_ovf got %b exp 0", Overflow); end
        n_vec++; if (In_Data !== 16'h0)   begin n_err++; $display("FAIL reset_data got %h exp 0000", In_Data); end
        Reset = 0;
        step();
        n_vec++; if (In_Rdy !== 1'b0)     begin n_err++; $display("FAIL post_reset_rdy got %b exp 0", In_Rdy); end
    endtask

    task automatic test_latency();
        Pins_In = 8'hA5; Strobe_In = 1;
        for (int e = 0; e < 20; e++) begin
            step();
            n_vec++;
            if (In_Rdy !== (e >= 7)) begin
                n_err++; $display("FAIL latency_rdy edge %0d got %b exp %b", e, In_Rdy, (e >= 7));
            end
            if (e >= 7) begin
                n_vec++;
                if (In_Data !== 16'h00A5) begin n_err++; $display("FAIL latency_data edge %0d got %h exp 00a5", e, In_Data); end
            end
        end
        Strobe_In = 0;
        repeat (8) step();
        n_vec++; if (In_Full !== 1'b0) begin n_err++; $display("FAIL one_entry_full got %b exp 0", In_Full); end
        In_Rd = 1; step(); In_Rd = 0;
        n_vec++; if (In_Rdy !== 1'b0) begin n_err++; $display("FAIL one_entry_drain got %b exp 0", In_Rdy); end
    endtask

    task automatic test_glitch();
        Pins_In = 8'h5A; Strobe_In = 1;
        repeat (3) step();
        Strobe_In = 0;
        for (int e = 0; e < 12; e++) begin
            step();
            n_vec++;
            if (In_Rdy !== 1'b0) begin n_err++; $display("FAIL glitch_rdy cycle %0d got %b exp 0", e, In_Rdy); end
        end
    endtask

    task automatic test_overflow();
        press(8'h11, 0, 0); press(8'h22, 0, 0); press(8'h33, 0, 0);
        n_vec++; if (In_Full !== 1'b1)   begin n_err++; $display("FAIL ovf_full got %b exp 1", In_Full); end
        n_vec++; if (Overflow !== 1'b1)  begin n_err++; $display("FAIL ovf_flag got %b exp 1", Overflow); end
        n_vec++; if (In_Data !== 16'h0011) begin n_err++; $display("FAIL ovf_head1 got %h exp 0011", In_Data); end
        In_Rd = 1; step();
        n_vec++; if (In_Data !== 16'h0022) begin n_err++; $display("FAIL ovf_head2 got %h exp 0022", In_Data); end
        step();
        n_vec++; if (In_Rdy !== 1'b0)    begin n_err++; $display("FAIL ovf_drained got %b exp 0", In_Rdy); end
        step(); In_Rd = 0;
        n_vec++; if (In_Rdy !== 1'b0 || In_Full !== 1'b0) begin
            n_err++; $display("FAIL pop_empty got rdy %b full %b exp 0 0", In_Rdy, In_Full);
        end
    endtask

    task automatic test_clr_ovf();
        Clr_Ovf = 1; step(); Clr_Ovf = 0;
        n_vec++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL clr_alone got %b exp 0", Overflow); end
        press(8'h44, 0, 0); press(8'h55, 0, 0); press(8'h66, 0, 1);
        n_vec++; if (Overflow !== 1'b1) begin n_err++; $display("FAIL clr_vs_drop got %b exp 1", Overflow); end
        n_vec++; if (In_Data !== 16'h0044) begin n_err++; $display("FAIL clr_head got %h exp 0044", In_Data); end
        In_Rd = 1; repeat (2) step(); In_Rd = 0;
        Clr_Ovf = 1; step(); Clr_Ovf = 0;
        n_vec++; if (Overflow !== 1'b0 || In_Rdy !== 1'b0) begin
            n_err++; $display("FAIL clr_final got ovf %b rdy %b exp 0 0", Overflow, In_Rdy);
        end
    endtask

    task automatic test_push_pop_full();
        press(8'h11, 0, 0); press(8'h22, 0, 0);
        n_vec++; if (In_Full !== 1'b1) begin n_err++; $display("FAIL ppf_fill got %b exp 1", In_Full); end
        press(8'h33, 1, 0);
        n_vec++; if (In_Full !== 1'b1)   begin n_err++; $display("FAIL ppf_count got %b exp 1", In_Full); end
        n_vec++; if (Overflow !== 1'b0)  begin n_err++; $display("FAIL ppf_ovf got %b exp 0", Overflow); end
        n_vec++; if (In_Data !== 16'h0022) begin n_err++; $display("FAIL ppf_head got %h exp 0022", In_Data); end
        In_Rd = 1; step();
        n_vec++; if (In_Data !== 16'h0033) begin n_err++; $display("FAIL ppf_new got %h exp 0033", In_Data); end
        step(); In_Rd = 0;
        n_vec++; if (In_Rdy !== 1'b0) begin n_err++; $display("FAIL ppf_drain got %b exp 0", In_Rdy); end
    endtask

    task automatic test_reset_mid();
        press(8'h77, 0, 0);
        Pins_In = 8'h99; Strobe_In = 1;
        repeat (3) step();
        #2 Reset = 1;
        #1;
        n_vec++; if (In_Rdy !== 1'b0 || In_Full !== 1'b0 || Overflow !== 1'b0 || In_Data !== 16'h0) begin
            n_err++; $display("FAIL async_reset got rdy %b full %b ovf %b data %h exp 0 0 0 0000",
                              In_Rdy, In_Full, Overflow, In_Data);
        end
        Strobe_In = 0;
        @(negedge Clk);
        Reset = 0;
        repeat (2) step();
        Pins_In = 8'h3C; Strobe_In = 1;
        for (int e = 0; e < 10; e++) begin
            step();
            n_vec++;
            if (In_Rdy !== (e >= 7)) begin
                n_err++; $display("FAIL rst_latency edge %0d got %b exp %b", e, In_Rdy, (e >= 7));
            end
        end
        n_vec++; if (In_Data !== 16'h003C) begin n_err++; $display("FAIL rst_data got %h exp 003c", In_Data); end
        Strobe_In = 0;
        repeat (8) step();
        In_Rd = 1; step(); In_Rd = 0;
    endtask

    task automatic test_random();
        int          run = 0;
        logic [15:0] exp_data;
        for (int c = 0; c < 800; c++) begin
            if (run == 0) begin
                Strobe_In = ~Strobe_In;
                run = $urandom_range(1, 8);
            end
            run--;
            Pins_In = 8'($urandom);
            In_Rd   = ($urandom_range(0, 3) == 0);
            Clr_Ovf = ($urandom_range(0, 15) == 0);
            step();
            exp_data = (mq.size() != 0) ? mq[0] : 16'h0;
            n_vec++; if (In_Rdy !== (mq.size() != 0)) begin
                n_err++; $display("FAIL rand_rdy cycle %0d got %b exp %b", c, In_Rdy, (mq.size() != 0));
            end
            n_vec++; if (In_Full !== (mq.size() == DEPTH)) begin
                n_err++; $display("FAIL rand_full cycle %0d got %b exp %b", c, In_Full, (mq.size() == DEPTH));
            end
            n_vec++; if (Overflow !== m_ovf) begin
                n_err++; $display("FAIL rand_ovf cycle %0d got %b exp %b", c, Overflow, m_ovf);
            end
            if (mq.size() != 0) begin
                n_vec++;
                if (In_Data !== exp_data) begin
                    n_err++; $display("FAIL rand_data cycle %0d got %h exp %h", c, In_Data, exp_data);
                end
            end
        end
        In_Rd = 0; Clr_Ovf = 0; Strobe_In = 0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_overflow();
        test_clr_ovf();
        test_push_pop_full();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
